// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multi-cycle 16-bit CPU: owns the PC, fetches words from
// instruction memory, holds each instruction until the datapath retires it,
// applies jump/branch redirects and parks in a halted state after HLT.
module instr_fetch_unit #(
    parameter int                    WORD_WIDTH  = 16,
    parameter logic [WORD_WIDTH-1:0] RESET_PC    = 16'h0000,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   i_readM,
    output logic [WORD_WIDTH-1:0]  i_address,
    input  logic [WORD_WIDTH-1:0]  i_data,
    input  logic                   inputReady,
    input  logic                   instr_ack,
    input  logic                   redirect_valid,
    input  logic [WORD_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    output logic [WORD_WIDTH-1:0]  instr,
    output logic [3:0]             opcode,
    output logic [5:0]             func,
    output logic [1:0]             rs,
    output logic [1:0]             rt,
    output logic [1:0]             rd,
    output logic [7:0]             imm,
    output logic [11:0]            target,
    output logic [WORD_WIDTH-1:0]  pc_plus1,
    output logic                   is_halted,
    output logic [COUNT_WIDTH-1:0] num_inst
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_t;

    localparam logic [WORD_WIDTH-1:0]  PC_ONE    = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                next_state;
    logic [WORD_WIDTH-1:0] pc;
    logic                  fetch_fire;
    logic                  retire;
    logic                  held_is_hlt;

    // HLT is opcode F with function code 29; other F-group words retire normally.
    assign held_is_hlt = (instr[15:12] == 4'hF) && (instr[5:0] == 6'd29);

    // State register; reset drops any outstanding request by returning to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a redirect in fetch suppresses capture of the returning word.
    always_comb begin
        next_state = state;
        fetch_fire = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                if (!redirect_valid && inputReady) begin
                    fetch_fire = 1'b1;
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ack) begin
                    retire     = 1'b1;
                    next_state = held_is_hlt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // PC, instruction register, link value and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= '0;
            pc_plus1 <= '0;
            num_inst <= '0;
        end else begin
            if (state == S_FETCH && redirect_valid) begin
                pc <= redirect_pc;
            end else if (fetch_fire) begin
                instr    <= i_data;
                pc_plus1 <= pc + PC_ONE;
                pc       <= pc + PC_ONE;
            end else if (retire && redirect_valid) begin
                pc <= redirect_pc;
            end
            if (retire) begin
                num_inst <= num_inst + COUNT_ONE;
            end
        end
    end

    // The request is masked while reset is held so memory never sees a stale read.
    assign i_readM     = (state == S_FETCH) && !reset;
    assign i_address   = pc;
    assign instr_valid = (state == S_HOLD);
    assign is_halted   = (state == S_HALT);

    assign opcode = instr[15:12];
    assign func   = instr[5:0];
    assign rs     = instr[11:10];
    assign rt     = instr[9:8];
    assign rd     = instr[7:6];
    assign imm    = instr[7:0];
    assign target = instr[11:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of per-cycle vectors for the
// main fetch/hold/redirect/halt flow, then hand-written multi-cycle sequences.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        inputReady;
    logic        instr_ack;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [1:0]  rd;
    logic [7:0]  imm;
    logic [11:0] target;
    logic [15:0] pc_plus1;
    logic        is_halted;
    logic [15:0] num_inst;

    int checks;
    int passes;

    instr_fetch_unit #(
        .WORD_WIDTH (16),
        .RESET_PC   (16'h0000),
        .COUNT_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_readM       (i_readM),
        .i_address     (i_address),
        .i_data        (i_data),
        .inputReady    (inputReady),
        .instr_ack     (instr_ack),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .opcode        (opcode),
        .func          (func),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .imm           (imm),
        .target        (target),
        .pc_plus1      (pc_plus1),
        .is_halted     (is_halted),
        .num_inst      (num_inst)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus: inputs are {rst, rdy, data, ack, rv, rpc};
    // expectations are the outputs seen during that cycle, before its rising edge.
    typedef struct {
        logic        rst;
        logic        rdy;
        logic [15:0] data;
        logic        ack;
        logic        rv;
        logic [15:0] rpc;
        logic        e_readM;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pp1;
        logic        e_halted;
        logic [15:0] e_num;
    } vec_t;

    vec_t vecs[18];

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [15:0] data,
                                 input logic ack, input logic rv, input logic [15:0] rpc);
        @(negedge clk);
        reset          = rst;
        inputReady     = rdy;
        i_data         = data;
        instr_ack      = ack;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end else begin
            passes++;
        end
    endtask

    initial begin
        checks         = 0;
        passes         = 0;
        reset          = 1'b1;
        inputReady     = 1'b0;
        i_data         = 16'h0000;
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        //           rst  rdy  data      ack  rv   rpc        rdM  addr      val  instr     pp1       hlt  num
        vecs[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'd0};
        vecs[1]  = '{1'b0,1'b1,16'h6101,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'd0};
        vecs[2]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0001,1'b1,16'h6101,16'h0001,1'b0,16'd0};
        vecs[3]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0001,1'b1,16'h6101,16'h0001,1'b0,16'd0};
        vecs[4]  = '{1'b0,1'b1,16'h6202,1'b0,1'b0,16'h0000, 1'b1,16'h0001,1'b0,16'h6101,16'h0001,1'b0,16'd1};
        vecs[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0300, 1'b0,16'h0002,1'b1,16'h6202,16'h0002,1'b0,16'd1};
        vecs[6]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0002,1'b1,16'h6202,16'h0002,1'b0,16'd1};
        vecs[7]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h6202,16'h0002,1'b0,16'd2};
        vecs[8]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h6202,16'h0002,1'b0,16'd2};
        vecs[9]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h6202,16'h0002,1'b0,16'd2};
        vecs[10] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0005, 1'b0,16'h0003,1'b1,16'h1234,16'h0003,1'b0,16'd2};
        vecs[11] = '{1'b0,1'b1,16'h7000,1'b0,1'b0,16'h0000, 1'b1,16'h0005,1'b0,16'h1234,16'h0003,1'b0,16'd3};
        vecs[12] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0040, 1'b0,16'h0006,1'b1,16'h7000,16'h0006,1'b0,16'd3};
        vecs[13] = '{1'b0,1'b1,16'hABCD,1'b0,1'b1,16'h0080, 1'b1,16'h0040,1'b0,16'h7000,16'h0006,1'b0,16'd4};
        vecs[14] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0080,1'b0,16'h7000,16'h0006,1'b0,16'd4};
        vecs[15] = '{1'b0,1'b1,16'hF01D,1'b0,1'b0,16'h0000, 1'b1,16'h0080,1'b0,16'h7000,16'h0006,1'b0,16'd4};
        vecs[16] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0081,1'b1,16'hF01D,16'h0081,1'b0,16'd4};
        vecs[17] = '{1'b0,1'b1,16'h1111,1'b1,1'b1,16'h0010, 1'b0,16'h0081,1'b0,16'hF01D,16'h0081,1'b1,16'd5};

        repeat (2) @(negedge clk);

        $display("[TB] table-driven fetch/hold/redirect/halt flow");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].data,
                          vecs[i].ack, vecs[i].rv, vecs[i].rpc);
            checkOutput($sformatf("v%0d.i_readM", i),     {31'd0, i_readM},     {31'd0, vecs[i].e_readM});
            checkOutput($sformatf("v%0d.i_address", i),   {16'd0, i_address},   {16'd0, vecs[i].e_addr});
            checkOutput($sformatf("v%0d.instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            checkOutput($sformatf("v%0d.instr", i),       {16'd0, instr},       {16'd0, vecs[i].e_instr});
            checkOutput($sformatf("v%0d.pc_plus1", i),    {16'd0, pc_plus1},    {16'd0, vecs[i].e_pp1});
            checkOutput($sformatf("v%0d.is_halted", i),   {31'd0, is_halted},   {31'd0, vecs[i].e_halted});
            checkOutput($sformatf("v%0d.num_inst", i),    {16'd0, num_inst},    {16'd0, vecs[i].e_num});
        end

        // Halted: every input pattern is ignored and nothing is requested.
        $display("[TB] halt hold for 20 cycles");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0020);
            checkOutput("halt.i_readM",   {31'd0, i_readM},   32'd0);
            checkOutput("halt.is_halted", {31'd0, is_halted}, 32'd1);
            checkOutput("halt.num_inst",  {16'd0, num_inst},  32'd5);
            checkOutput("halt.i_address", {16'd0, i_address}, 32'h0081);
        end

        // Reset out of halt.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("rst_in.i_readM", {31'd0, i_readM}, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("unhalt.i_address", {16'd0, i_address}, 32'h0000);
        checkOutput("unhalt.is_halted", {31'd0, is_halted}, 32'd0);
        checkOutput("unhalt.i_readM",   {31'd0, i_readM},   32'd1);
        checkOutput("unhalt.num_inst",  {16'd0, num_inst},  32'd0);
        checkOutput("unhalt.instr",     {16'd0, instr},     32'h0000);

        // PC wrap at 16'hFFFF plus decode of every field.
        $display("[TB] PC wrap and field decode");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 16'hB6C5, 1'b0, 1'b0, 16'h0000);
        checkOutput("wrap.fetch_addr", {16'd0, i_address}, 32'hFFFF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("wrap.instr_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("wrap.pc_plus1",    {16'd0, pc_plus1},    32'h0000);
        checkOutput("wrap.i_address",   {16'd0, i_address},   32'h0000);
        checkOutput("dec.opcode", {28'd0, opcode}, 32'hB);
        checkOutput("dec.rs",     {30'd0, rs},     32'd1);
        checkOutput("dec.rt",     {30'd0, rt},     32'd2);
        checkOutput("dec.rd",     {30'd0, rd},     32'd3);
        checkOutput("dec.imm",    {24'd0, imm},    32'hC5);
        checkOutput("dec.func",   {26'd0, func},   32'd5);
        checkOutput("dec.target", {20'd0, target}, 32'h6C5);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

        // Opcode F with a non-HLT function code must not halt.
        applyStimulus(1'b0, 1'b1, 16'hF03D, 1'b0, 1'b0, 16'h0000);
        checkOutput("f3d.fetch_readM", {31'd0, i_readM},   32'd1);
        checkOutput("f3d.fetch_addr",  {16'd0, i_address}, 32'h0000);
        checkOutput("f3d.num_inst",    {16'd0, num_inst},  32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        checkOutput("f3d.opcode", {28'd0, opcode}, 32'hF);
        checkOutput("f3d.func",   {26'd0, func},   32'h3D);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("f3d.is_halted", {31'd0, is_halted}, 32'd0);
        checkOutput("f3d.i_readM",   {31'd0, i_readM},   32'd1);
        checkOutput("f3d.i_address", {16'd0, i_address}, 32'h0001);
        checkOutput("f3d.num_inst2", {16'd0, num_inst},  32'd2);

        // Reset lands on the same edge as a late inputReady of a pending fetch.
        $display("[TB] reset during pending fetch");
        applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
        checkOutput("rstpend.i_readM", {31'd0, i_readM}, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("rstpend.i_address",   {16'd0, i_address},   32'h0000);
        checkOutput("rstpend.instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rstpend.instr",       {16'd0, instr},       32'h0000);
        checkOutput("rstpend.i_readM2",    {31'd0, i_readM},     32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("rstpend.still_idle", {31'd0, instr_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multi-cycle 16-bit CPU.
- Owns the PC and requests instruction words from instruction memory over a ready handshake.
- Latches each word into an instruction register and presents the decoded fields (opcode, func, register fields, immediates) to the control unit and datapath.
- Holds each instruction until the datapath acknowledges completion, applies jump/branch redirects, and stops fetching on HLT.

Parameters:
- WORD_WIDTH, 16, width of PC, instruction word and memory address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_readM  out  1  instruction memory read request.
- i_address  out  WORD_WIDTH  instruction memory address (equals PC).
- i_data  in  WORD_WIDTH  instruction word from memory, valid when inputReady=1.
- inputReady  in  1  memory has returned i_data for the current request.
- instr_ack  in  1  datapath has finished the current instruction; single-cycle pulse.
- redirect_valid  in  1  a jump or taken branch is resolved this cycle.
- redirect_pc  in  WORD_WIDTH  target PC for the redirect.
- instr_valid  out  1  instruction register holds a live instruction.
- instr  out  WORD_WIDTH  raw instruction register.
- opcode  out  4  instr[15:12].
- func  out  6  instr[5:0].
- rs  out  2  instr[11:10].
- rt  out  2  instr[9:8].
- rd  out  2  instr[7:6].
- imm  out  8  instr[7:0], unextended.
- target  out  12  instr[11:0].
- pc_plus1  out  WORD_WIDTH  address of the held instruction + 1; JAL link value.
- is_halted  out  1  HLT retired; fetching stopped.
- num_inst  out  COUNT_WIDTH  count of retired instructions.

Behaviour:
- Reset is synchronous and active-high; clk is the single clock.
- Reset values: PC=RESET_PC, state=S_FETCH, instr=0, pc_plus1=0, i_readM=0, instr_valid=0, is_halted=0, num_inst=0.
- Reset dominates every other input in the same cycle.
- Reset asserted mid-operation abandons any outstanding request. A late inputReady arriving after reset is ignored unless a new request is open.
- States: S_FETCH, S_HOLD, S_HALT.
- S_FETCH:
  - i_readM=1 combinationally; i_address=PC.
  - On an edge with inputReady=1: instr<=i_data, pc_plus1<=PC+1, PC<=PC+1, go to S_HOLD.
  - Minimum latency from entering S_FETCH to instr_valid=1 is one cycle (memory ready the same cycle).
- S_FETCH with redirect_valid=1 on the same edge:
  - Redirect wins: PC<=redirect_pc, stay in S_FETCH, i_data discarded even if inputReady=1.
  - The next cycle issues a fresh request at the new PC.
- S_HOLD:
  - i_readM=0; instr_valid=1; decoded fields driven combinationally from instr.
  - On an edge with instr_ack=1: num_inst<=num_inst+1.
  - If redirect_valid=1 on that edge, PC<=redirect_pc; otherwise PC keeps the incremented value.
  - If the held instruction is HLT (opcode=4'hF and func=6'd29), go to S_HALT. Otherwise go to S_FETCH.
  - redirect_valid without instr_ack in S_HOLD is ignored.
  - instr_ack in S_FETCH or S_HALT is ignored.
- S_HALT:
  - i_readM=0, instr_valid=0, is_halted=1.
  - PC, instr and num_inst are frozen. Only reset exits.
- Arithmetic and wrap-around:
  - PC+1 wraps modulo 2^WORD_WIDTH (16'hFFFF -> 16'h0000), no flag.
  - num_inst wraps modulo 2^COUNT_WIDTH.
- i_address equals PC in every state; it is only meaningful while i_readM=1.
- Decoded outputs are pure wiring from instr; they hold their last value when instr_valid=0.

Test Plan:
- Reset with memory returning data the same cycle; words 16'h6101 at 0 and 16'h6202 at 1, ack each after 2 cycles -> first instr_valid 1 cycle after reset release. i_address sequence is 0, 1, 2; opcode=4'h6, rs=0, rt=1, imm=8'h01 on the first instruction; num_inst=2 after both acks.
- Memory with 3-cycle latency -> i_readM held high and i_address stable for 3 cycles. Exactly one instruction is latched, and instr_valid rises the cycle after inputReady.
- Jump at PC=5 with instr_ack and redirect_valid=1, redirect_pc=16'h0040 -> next i_address=16'h0040, pc_plus1 during the hold was 16'h0006, num_inst increments by 1.
- Redirect to 16'h0080 in S_FETCH on the same edge as inputReady with data 16'hABCD -> data is not latched, instr_valid stays 0, and the next request goes to 16'h0080.
- HLT word 16'hF01D at PC=3 is acked -> is_halted=1, i_readM stays 0 for 20+ cycles, num_inst frozen. Reset then returns to PC=0 with is_halted=0.
- PC=16'hFFFF fetch, then ack -> next i_address=16'h0000. Reset asserted during a pending 3-cycle fetch -> PC=RESET_PC, instr_valid=0, and the stale inputReady is not captured.
